div_32_bit_seq: RTL and testbench
=================================

// Module: div_32_bit_seq
// PURPOSE
//  Iterative signed 32-bit integer divider for the multdiv unit; the subtractive counterpart to the adders.
//  Restoring algorithm: one quotient bit per cycle, trial subtract done as A + ~B + 1 with the carry-select adder.
//  Sits beside the multiplier behind the ctrl_div / data_resultRDY handshake used by the processor stall logic.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width (even, >= 4)
//  CW     6   iteration counter width; must hold WIDTH
// PORTS
//  clock            in   1      single clock, rising edge
//  reset_n          in   1      asynchronous, active-low reset
//  ctrl_div         in   1      start pulse; operands sampled on this edge
//  data_operandA    in   WIDTH  dividend, two's complement
//  data_operandB    in   WIDTH  divisor, two's complement
//  data_result      out  WIDTH  quotient, truncated toward zero
//  data_exception   out  1      divide-by-zero or overflow flag for this result
//  data_resultRDY   out  1      one-cycle pulse: result/exception valid
// BEHAVIOUR
//  Reset: async on reset_n=0 -> state IDLE, counter 0, all outputs 0, internal regs 0; mid-op reset aborts, no RDY.
//  FSM: IDLE -> (ctrl_div) RUN -> (counter==WIDTH-1) DONE -> IDLE; IDLE -> (ctrl_div & B==0) DONE.
//  Capture (ctrl_div edge): latch |A|, |B|, sign = A[MSB]^B[MSB]; clear partial remainder, counter=0.
//  RUN: each cycle shift {rem,quo} left 1, trial = rem - |B|; if no borrow (adder Cout=1) rem=trial, quo[0]=1.
//  Latency: ctrl_div at edge 0 -> data_resultRDY high for exactly the cycle after edge WIDTH+1 (33 cycles default).
//  Divide-by-zero: RDY pulses after edge 1; data_result=0, data_exception=1; no iterations run.
//  Overflow (A=-2^(WIDTH-1), B=-1): full latency; data_result=0x8000_0000, data_exception=1.
//  Sign fix in DONE: quotient negated if sign=1 (zero stays zero); exception=0 for all normal results.
//  data_result/data_exception held stable from RDY until next ctrl_div; cleared to 0 on the cycle after ctrl_div.
//  ctrl_div while RUN/DONE: abandon current op, recapture operands, restart count; no RDY for aborted op.
//  ctrl_div held high multiple cycles: each high edge restarts; RDY follows the last one.
//  data_resultRDY never high two consecutive cycles; never high in IDLE without a preceding DONE.
//  Operands may change after capture edge without affecting the result.
// CONFIGURATION
//  DIV_REMAINDER_EN defined: adds output port data_remainder [WIDTH-1:0]; remainder sign follows dividend,
//   valid/held with data_result; reset 0; 0 on divide-by-zero, 0 on overflow case.
//  DIV_REMAINDER_EN undefined: port absent, remainder register still used internally but not exported;
//   all other timing/behaviour identical.
// TESTING
//  A=100, B=7, pulse ctrl_div -> RDY 33 cycles later, result=14, exception=0 (rem=2 with macro).
//  A=-100, B=7 -> result=-14 (0xFFFF_FFF2), exception=0 (rem=-2 with macro); A=100,B=-7 -> -14, rem=2.
//  A=5, B=0 -> RDY after 1 cycle, result=0, exception=1.
//  A=0x8000_0000, B=-1 -> RDY at 33 cycles, result=0x8000_0000, exception=1.
//  Start A=50,B=5; at cycle 10 pulse ctrl_div A=9,B=3 -> single RDY 33 cycles after 2nd pulse, result=3.
//  Start A=50,B=5; drop reset_n at cycle 20 -> outputs 0 immediately, no RDY; new op after release correct.

Source files
------------

// File: rtl/div_32_bit_seq.sv
// div_32_bit_seq: iterative signed divider for the multdiv unit.
// Restoring algorithm that produces one quotient bit per cycle. Each trial
// subtract is computed as rem + ~|B| + 1 on a two-block carry-select adder.
// Operands are sampled on a ctrl_div edge, and data_resultRDY pulses for one
// cycle when data_result and data_exception become valid. Both outputs then
// hold until the next ctrl_div.
// Optional feature: define DIV_REMAINDER_EN to export data_remainder. The
// remainder takes the sign of the dividend.
module div_32_bit_seq #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int H = WIDTH / 2;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;          // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] b_abs_q, b_abs_d;
  logic             sign_q, sign_d;        // quotient sign
  logic             a_neg_q, a_neg_d;      // remainder sign
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;

  // Trial-subtract operands and results.
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] trial;
  logic             trial_cout;
  logic [H-1:0]     lo_sum;
  logic             lo_cout;
  logic [H:0]       hi_c0, hi_c1;

  assign rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign b_inv     = ~b_abs_q;

  // Carry-select trial subtract. The upper half is computed for both carry-in
  // values and selected by the lower half's carry. Cout=1 means no borrow.
  always_comb begin
    {lo_cout, lo_sum} = {1'b0, rem_shift[H-1:0]} + {1'b0, b_inv[H-1:0]} + (H+1)'(1);
    hi_c0 = {1'b0, rem_shift[WIDTH-1:H]} + {1'b0, b_inv[WIDTH-1:H]};
    hi_c1 = {1'b0, rem_shift[WIDTH-1:H]} + {1'b0, b_inv[WIDTH-1:H]} + (H+1)'(1);
    trial      = {(lo_cout ? hi_c1[H-1:0] : hi_c0[H-1:0]), lo_sum};
    trial_cout = lo_cout ? hi_c1[H] : hi_c0[H];
  end

  // Next-state logic. A ctrl_div pulse in any state restarts the divider.
  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (ctrl_div) begin
      state_d = (data_operandB == '0) ? DONE : RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: operand capture, one restoring step, and sign fix.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    b_abs_d   = b_abs_q;
    sign_d    = sign_q;
    a_neg_d   = a_neg_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    rem_out_d = rem_out_q;
    if (ctrl_div) begin
      a_neg_d   = data_operandA[WIDTH-1];
      sign_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      quo_d     = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
      b_abs_d   = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
      rem_d     = '0;
      cnt_d     = '0;
      dbz_d     = (data_operandB == '0);
      ovf_d     = (data_operandA == MIN_NEG) && (data_operandB == '1);
      result_d  = '0;
      exc_d     = 1'b0;
      rem_out_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          rem_d = trial_cout ? trial : rem_shift;
          quo_d = {quo_q[WIDTH-2:0], trial_cout};
          cnt_d = cnt_q + CW'(1);
        end
        DONE: begin
          rdy_d = 1'b1;
          exc_d = dbz_q | ovf_q;
          if (dbz_q) begin
            result_d = '0;
          end else begin
            // The overflow case produces quo = 0x8000_0000 with positive sign.
            result_d = sign_q ? (~quo_q + WIDTH'(1)) : quo_q;
          end
          if (dbz_q || ovf_q) begin
            rem_out_d = '0;
          end else begin
            rem_out_d = a_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state register.
  // NOTE: sequential blocks use non-blocking assignments only, so every flop
  // samples values from before the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath and output registers.
  // NOTE: this design holds only a few registers and no memory array, so every
  // register is reset. A mid-operation reset therefore leaves nothing stale.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      b_abs_q   <= '0;
      sign_q    <= 1'b0;
      a_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      rem_out_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      b_abs_q   <= b_abs_d;
      sign_q    <= sign_d;
      a_neg_q   <= a_neg_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
      rem_out_q <= rem_out_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
`ifdef DIV_REMAINDER_EN
  assign data_remainder = rem_out_q;
`else
  // Without the export, the signed remainder register has no load.
  logic unused_rem;
  assign unused_rem = ^rem_out_q;
`endif

endmodule

// File: tb/tb_div_32_bit_seq.sv
// Self-checking bench for div_32_bit_seq: directed spec vectors, random
// operands against an arithmetic reference model, restart, held start, reset.
module tb_div_32_bit_seq;

  localparam int WIDTH = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clock;
  logic        reset_n;
  logic        ctrl_div;
  logic [31:0] opA, opB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [31:0] rem_w;

  int checks = 0;
  int errors = 0;

  div_32_bit_seq #(.WIDTH(32), .CW(6)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (rem_w)
`endif
  );

`ifndef DIV_REMAINDER_EN
  assign rem_w = '0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: plain signed arithmetic with the two exception cases.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic e,
                                output logic [31:0] r);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) begin
      q = 0; e = 1'b1; r = 0;
    end else if (a == MIN_NEG && b == 32'hFFFF_FFFF) begin
      q = MIN_NEG; e = 1'b1; r = 0;
    end else begin
      q = 32'(sa / sb); e = 1'b0; r = 32'(sa % sb);
    end
  endfunction

  // One-cycle start pulse. The operands are scrambled right after capture.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_div = 1'b1; opA = a; opB = b;
    @(negedge clock);
    ctrl_div = 1'b0; opA = $urandom; opB = $urandom;
  endtask

  // Count cycles after the capture edge until RDY appears. lat = -1 on timeout.
  task automatic wait_rdy(output int lat, output logic [31:0] q, output logic e,
                          output logic [31:0] r);
    lat = -1; q = 'x; e = 1'bx; r = 'x;
    for (int k = 1; k <= WIDTH + 10; k++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        lat = k; q = data_result; e = data_exception; r = rem_w;
        return;
      end
    end
  endtask

  // Full operation: verify clear-on-start, latency, values, single pulse, and hold.
  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er, gq, gr;
    logic ee, ge;
    int lat, exp_lat;
    model(a, b, eq, ee, er);
    exp_lat = (b == 0) ? 1 : WIDTH + 1;
    start_op(a, b);
    checks++;
    if (data_result !== 32'h0 || data_exception !== 1'b0) begin
      errors++;
      $display("FAIL %s clear: result=%h exc=%b expected 0/0", name, data_result, data_exception);
    end
    wait_rdy(lat, gq, ge, gr);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    if (lat >= 0) begin
      checks++;
      if (gq !== eq || ge !== ee) begin
        errors++;
        $display("FAIL %s result: a=%h b=%h got %h/%b expected %h/%b", name, a, b, gq, ge, eq, ee);
      end
`ifdef DIV_REMAINDER_EN
      checks++;
      if (gr !== er) begin
        errors++;
        $display("FAIL %s remainder: got %h expected %h", name, gr, er);
      end
`endif
      @(negedge clock);
      checks++;
      if (data_resultRDY !== 1'b0 || data_result !== eq || data_exception !== ee) begin
        errors++;
        $display("FAIL %s hold: rdy=%b result=%h exc=%b expected 0/%h/%b",
                 name, data_resultRDY, data_result, data_exception, eq, ee);
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ctrl_div = 1'b0; opA = '0; opB = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (data_result !== 0 || data_exception !== 0 || data_resultRDY !== 0 || rem_w !== 0) begin
      errors++;
      $display("FAIL reset: result=%h exc=%b rdy=%b rem=%h expected all 0",
               data_result, data_exception, data_resultRDY, rem_w);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL idle_rdy: got %b expected 0", data_resultRDY);
    end
  endtask

  task automatic test_directed;
    check_op("pos_pos", 32'd100, 32'd7);
    check_op("neg_pos", -32'sd100, 32'd7);
    check_op("pos_neg", 32'd100, -32'sd7);
    check_op("neg_neg", -32'sd100, -32'sd7);
    check_op("div_zero", 32'd5, 32'd0);
    check_op("overflow", MIN_NEG, 32'hFFFF_FFFF);
    check_op("min_by_one", MIN_NEG, 32'd1);
    check_op("zero_dividend", 32'd0, 32'd5);
    check_op("small_by_min", 32'hFFFF_FFFF, MIN_NEG);
    check_op("max_by_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 500);
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 100000);
      endcase
      check_op("random", a, b);
    end
  endtask

  task automatic test_restart;
    int lat, hits;
    logic [31:0] gq, gr;
    logic ge;
    hits = 0;
    start_op(32'd50, 32'd5);
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) hits++;
    end
    start_op(32'd9, 32'd3);
    wait_rdy(lat, gq, ge, gr);
    checks++;
    if (hits != 0 || lat != WIDTH + 1) begin
      errors++;
      $display("FAIL restart timing: early_rdy=%0d latency=%0d expected 0/%0d", hits, lat, WIDTH + 1);
    end
    checks++;
    if (gq !== 32'd3 || ge !== 1'b0) begin
      errors++;
      $display("FAIL restart result: got %h/%b expected 00000003/0", gq, ge);
    end
  endtask

  task automatic test_held_start;
    int lat;
    logic [31:0] gq, gr;
    logic ge;
    @(negedge clock);
    ctrl_div = 1'b1; opA = 32'd1000; opB = 32'd10;
    @(negedge clock);
    opA = 32'd77; opB = 32'd0;
    @(negedge clock);
    opA = -32'sd81; opB = 32'd9;
    @(negedge clock);
    ctrl_div = 1'b0; opA = $urandom; opB = $urandom;
    wait_rdy(lat, gq, ge, gr);
    checks++;
    if (lat != WIDTH + 1 || gq !== 32'hFFFF_FFF7 || ge !== 1'b0) begin
      errors++;
      $display("FAIL held_start: latency=%0d result=%h exc=%b expected %0d/fffffff7/0",
               lat, gq, ge, WIDTH + 1);
    end
  endtask

  task automatic test_reset_midop;
    int hits;
    hits = 0;
    // A held result must clear immediately on an asynchronous reset.
    check_op("pre_reset", 32'd100, 32'd7);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (data_result !== 0 || data_exception !== 0 || rem_w !== 0) begin
      errors++;
      $display("FAIL async_reset: result=%h exc=%b rem=%h expected 0", data_result, data_exception, rem_w);
    end
    @(negedge clock);
    reset_n = 1'b1;
    // Abort an operation in progress. No RDY may follow.
    start_op(32'd50, 32'd5);
    repeat (19) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (data_resultRDY !== 0 || data_result !== 0) begin
      errors++;
      $display("FAIL midop_reset: rdy=%b result=%h expected 0/0", data_resultRDY, data_result);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL aborted_rdy: got %0d pulses expected 0", hits);
    end
    check_op("post_reset", 32'd9, 32'd3);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_restart();
    test_held_start();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
